lb_ram_access_ctrl: RTL and testbench

LB_RAM_ACCESS_CTRL -- requirements
Module: lb_ram_access_ctrl

---
 rtl/lb_ram_pkg.sv | 22 ++
 rtl/lb_ram_rsp_fifo.sv | 72 +++++++
 rtl/lb_ram_access_ctrl.sv | 100 ++++++++++
 tb/tb_lb_ram_access_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_ram_pkg.sv
// Shared constants and request type for the local-bus SRAM access controller.
// Define LB_RAM_RSP_SKID_EN for a 2-entry response buffer (one read per cycle); otherwise 1 entry.
package lb_ram_pkg;

    localparam int LB_RAM_ADDR_W = 8;
    localparam int LB_RAM_DATA_W = 128;
    localparam int LB_RAM_BE_W   = LB_RAM_DATA_W / 8;

`ifdef LB_RAM_RSP_SKID_EN
    localparam int LB_RAM_RSP_DEPTH = 2;
`else
    localparam int LB_RAM_RSP_DEPTH = 1;
`endif

    typedef struct packed {
        logic                     we;
        logic [LB_RAM_ADDR_W-1:0] addr;
        logic [LB_RAM_DATA_W-1:0] wdata;
        logic [LB_RAM_BE_W-1:0]   be;
    } lb_ram_req_t;

endpackage

// File: rtl/lb_ram_rsp_fifo.sv
// In-order response buffer holding SRAM read data until the requester takes it.
// Push while full is legal only together with a pop in the same cycle.
module lb_ram_rsp_fifo
    import lb_ram_pkg::*;
#(
    parameter int  DEPTH  = LB_RAM_RSP_DEPTH,
    parameter int  DATA_W = LB_RAM_DATA_W,
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              do_push_s;
    logic              do_pop_s;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Occupancy next-state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lb_ram_access_ctrl.sv
// Local-bus to single-port SRAM access controller with an in-order read response buffer.
// Buffer depth is selected by LB_RAM_RSP_SKID_EN through lb_ram_pkg.
module lb_ram_access_ctrl
    import lb_ram_pkg::*;
#(
    parameter int ADDR_W = LB_RAM_ADDR_W,
    parameter int DATA_W = LB_RAM_DATA_W,
    parameter int BE_W   = LB_RAM_BE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_ceb,
    output logic              ram_web,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_d,
    output logic [BE_W-1:0]   ram_bweb,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int DEPTH = LB_RAM_RSP_DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    logic             inflight_q;
    logic             inflight_d;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic [CNT_W-1:0] count_s;
    logic [OCC_W-1:0] occ_s;

    // Reserve a buffer slot for every read in flight so ram_q always has a home.
    assign pop_s     = rsp_valid && rsp_ready;
    assign occ_s     = OCC_W'(count_s) + OCC_W'(inflight_q) - OCC_W'(pop_s);
    assign req_ready = rst_n && (occ_s < OCC_W'(DEPTH));
    assign rsp_valid = !empty_s;

    // SRAM strobes are driven in the accept cycle; idle drives all strobes inactive.
    always_comb begin
        ram_ceb    = 1'b1;
        ram_web    = 1'b1;
        ram_a      = {ADDR_W{1'b0}};
        ram_d      = {DATA_W{1'b0}};
        ram_bweb   = {BE_W{1'b1}};
        inflight_d = 1'b0;
        if (req_valid && req_ready) begin
            if (req_we) begin
                if (req_be != {BE_W{1'b0}}) begin
                    ram_ceb  = 1'b0;
                    ram_web  = 1'b0;
                    ram_a    = req_addr;
                    ram_d    = req_wdata;
                    ram_bweb = ~req_be;
                end else begin
                    ram_ceb = 1'b1;
                end
            end else begin
                ram_ceb    = 1'b0;
                ram_a      = req_addr;
                inflight_d = !full_s || pop_s;
            end
        end else begin
            ram_ceb = 1'b1;
        end
    end

    // Marks the cycle in which ram_q carries read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    lb_ram_rsp_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (ram_q),
        .pop_i       (pop_s),
        .full_o      (full_s),
        .empty_o     (empty_s),
        .head_o      (rsp_rdata),
        .count_o     (count_s)
    );

endmodule

// File: tb/tb_lb_ram_access_ctrl.sv
// Directed bench for lb_ram_access_ctrl with a behavioural SRAM model.
// Honours LB_RAM_RSP_SKID_EN for depth and back-to-back expectations.
module tb_lb_ram_access_ctrl;

`ifdef LB_RAM_RSP_SKID_EN
    localparam int DEPTH    = 2;
    localparam int B2B_SPAN = 8;
`else
    localparam int DEPTH    = 1;
    localparam int B2B_SPAN = 15;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_we;
    logic [7:0]   req_addr;
    logic [127:0] req_wdata;
    logic [15:0]  req_be;
    logic         rsp_valid, rsp_ready;
    logic [127:0] rsp_rdata;
    logic         ram_ceb, ram_web;
    logic [7:0]   ram_a;
    logic [127:0] ram_d;
    logic [15:0]  ram_bweb;
    logic [127:0] ram_q;
    logic [127:0] sram [256];

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] D_WR = 128'h0123456789ABCDEF0123456789ABCDEF;

    always #5 clk = ~clk;

    lb_ram_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_ceb(ram_ceb), .ram_web(ram_web), .ram_a(ram_a), .ram_d(ram_d),
        .ram_bweb(ram_bweb), .ram_q(ram_q)
    );

    // Single-port SRAM model: registered read data, per-byte active-low write mask.
    always @(posedge clk) begin
        if (!ram_ceb) begin
            if (!ram_web) begin
                for (int b = 0; b < 16; b++) begin
                    if (!ram_bweb[b]) sram[ram_a][b*8 +: 8] <= ram_d[b*8 +: 8];
                end
            end else begin
                ram_q <= sram[ram_a];
            end
        end
    end

    function automatic logic [127:0] pat(input int i);
        logic [15:0] w;
        w = 16'hA500 + 16'(i);
        return {8{w}};
    endfunction

    task automatic preload(input logic [7:0] a, input logic [127:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_be = 16'hFFFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h33; req_wdata = D_WR; req_be = 16'hFFFF;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if ({ram_ceb, ram_web, ram_bweb} !== {1'b1, 1'b1, 16'hFFFF}) begin
            errors++; $display("FAIL rst_strobes got %b %b %h exp 1 1 ffff", ram_ceb, ram_web, ram_bweb); end
        checks++; if ({ram_a, ram_d} !== {8'h00, 128'h0}) begin
            errors++; $display("FAIL rst_addr_data got %h %h exp 0 0", ram_a, ram_d); end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h05; req_wdata = D_WR; req_be = 16'hFFFF;
        #1;
        checks++; if ({req_ready, ram_ceb, ram_web, ram_bweb, ram_a, ram_d} !== {1'b1, 1'b0, 1'b0, 16'h0000, 8'h05, D_WR}) begin
            errors++; $display("FAIL wr_strobes got rdy=%b ceb=%b web=%b bweb=%h a=%h d=%h", req_ready, ram_ceb, ram_web, ram_bweb, ram_a, ram_d); end
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_be = 16'h1234;
        #1;
        checks++; if ({ram_ceb, ram_web, ram_bweb, ram_a} !== {1'b0, 1'b1, 16'hFFFF, 8'h05}) begin
            errors++; $display("FAIL rd_strobes got ceb=%b web=%b bweb=%h a=%h exp 0 1 ffff 05", ram_ceb, ram_web, ram_bweb, ram_a); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if ({rsp_valid, ram_ceb, ram_web} !== 3'b011) begin
            errors++; $display("FAIL rd_t1_idle got rsp_valid=%b ceb=%b web=%b exp 0 1 1", rsp_valid, ram_ceb, ram_web); end
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, D_WR}) begin
            errors++; $display("FAIL rd_t2_data got %b %h exp 1 %h", rsp_valid, rsp_rdata, D_WR); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_popped got %b exp 0", rsp_valid); end
    endtask

    task automatic test_partial_be;
        preload(8'h10, 128'h0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = {128{1'b1}}; req_be = 16'h0001;
        #1;
        checks++; if ({ram_ceb, ram_web, ram_bweb} !== {1'b0, 1'b0, 16'hFFFE}) begin
            errors++; $display("FAIL be1_bweb got ceb=%b web=%b bweb=%h exp 0 0 fffe", ram_ceb, ram_web, ram_bweb); end
        @(negedge clk);
        req_we = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 128'hFF}) begin
            errors++; $display("FAIL be1_read got %b %h exp 1 ff", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_be_zero;
        int seen;
        seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 128'h0; req_be = 16'h0000;
        #1;
        checks++; if ({ram_ceb, req_ready} !== 2'b11) begin
            errors++; $display("FAIL be0_noaccess got ceb=%b ready=%b exp 1 1", ram_ceb, req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1; if (rsp_valid) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL be0_no_rsp got %0d responses exp 0", seen); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk); #1;
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, 128'hFF}) begin
            errors++; $display("FAIL be0_mem_kept got %b %h exp 1 ff", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_back_to_back;
        int acc, rsp_n, first, last;
        acc = 0; rsp_n = 0; first = -1; last = -1;
        for (int i = 0; i < 8; i++) preload(8'(i), pat(i));
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            req_valid = (acc < 8); req_we = 1'b0; req_addr = 8'(acc);
            #1;
            if (rsp_valid) begin
                checks++;
                if (rsp_n >= 8 || rsp_rdata !== pat(rsp_n)) begin
                    errors++; $display("FAIL b2b_data idx %0d got %h exp %h", rsp_n, rsp_rdata, pat(rsp_n));
                end
                rsp_n++;
            end
            if (req_valid && req_ready) begin
                if (acc == 0) first = cyc;
                if (acc == 7) last = cyc;
                acc++;
            end
            if (acc == 8 && rsp_n == 8) break;
        end
        req_valid = 1'b0;
        checks++; if (acc !== 8 || rsp_n !== 8) begin errors++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp 8 8", acc, rsp_n); end
        checks++; if (last - first + 1 !== B2B_SPAN) begin
            errors++; $display("FAIL b2b_span got %0d exp %0d", last - first + 1, B2B_SPAN); end
    endtask

    task automatic test_backpressure;
        int acc, n;
        acc = 0; n = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(acc);
            #1;
            if (req_ready) acc++;
        end
        checks++; if (acc !== DEPTH || req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accepts got acc=%0d ready=%b exp %0d 0", acc, req_ready, DEPTH); end
        checks++; if ({rsp_valid, rsp_rdata} !== {1'b1, pat(0)}) begin
            errors++; $display("FAIL bp_head got %b %h exp 1 %h", rsp_valid, rsp_rdata, pat(0)); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rsp_rdata !== pat(0)) begin errors++; $display("FAIL bp_hold got %h exp %h", rsp_rdata, pat(0)); end
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            req_valid = 1'b0; rsp_ready = 1'b1;
            #1;
            if (rsp_valid) begin
                checks++;
                if (n >= DEPTH || rsp_rdata !== pat(n)) begin
                    errors++; $display("FAIL bp_drain idx %0d got %h exp %h", n, rsp_rdata, pat(n));
                end
                n++;
            end
        end
        checks++; if (n !== DEPTH) begin errors++; $display("FAIL bp_drain_count got %0d exp %0d", n, DEPTH); end
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h03;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({ram_ceb, req_ready, rsp_valid} !== 3'b100) begin
            errors++; $display("FAIL rmid_in_reset got ceb=%b ready=%b rsp_valid=%b exp 1 0 0", ram_ceb, req_ready, rsp_valid); end
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rmid_no_rsp got %0d responses exp 0", seen); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00;
        req_wdata = 128'h0; req_be = 16'h0000; rsp_ready = 1'b1;
        test_reset;
        test_write_read;
        test_partial_be;
        test_be_zero;
        test_back_to_back;
        test_backpressure;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
